// File: rtl/response_scheduler_pkg.sv
// Shared state encoding, frame length and defaults for response_scheduler.
// RESPONSE_CHECKSUM_EN selects three-byte frames (code, data, code^data).
package response_scheduler_pkg;

`ifdef RESPONSE_CHECKSUM_EN
    localparam int unsigned RESPONSE_FRAME_BYTES = 32'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_CODE = 3'd1,
        ST_WAIT_CODE = 3'd2,
        ST_SEND_DATA = 3'd3,
        ST_WAIT_DATA = 3'd4,
        ST_SEND_SUM  = 3'd5,
        ST_WAIT_SUM  = 3'd6
    } state_t;
`else
    localparam int unsigned RESPONSE_FRAME_BYTES = 32'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_CODE = 3'd1,
        ST_WAIT_CODE = 3'd2,
        ST_SEND_DATA = 3'd3,
        ST_WAIT_DATA = 3'd4
    } state_t;
`endif

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd100000;

    function automatic logic [7:0] frame_checksum(input logic [7:0] code, input logic [7:0] data);
        return code ^ data;
    endfunction

endpackage

// File: rtl/response_scheduler_arbiter.sv
// Combinational round-robin pick: the valid requester closest above last_grant_i,
// wrapping at NUM_REQ, plus a flag saying whether anything is pending.
module round_robin_arbiter #(
    parameter int unsigned NUM_REQ = 32'd4,
    parameter int unsigned GW      = 32'd2
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [GW-1:0]      last_grant_i,
    output logic [GW-1:0]      grant_o,
    output logic               valid_o
);
    int unsigned dist_s;
    int unsigned best_dist_s;
    logic        take_s;

    // Smallest upward distance from last_grant_i wins; distance 0 is the requester just after it.
    always_comb begin
        grant_o     = '0;
        valid_o     = 1'b0;
        dist_s      = 32'd0;
        best_dist_s = NUM_REQ;
        take_s      = 1'b0;
        for (int unsigned i = 32'd0; i < NUM_REQ; i++) begin
            dist_s      = (i + NUM_REQ - 32'(last_grant_i) - 32'd1) % NUM_REQ;
            take_s      = req_valid_i[i] && (dist_s < best_dist_s);
            best_dist_s = take_s ? dist_s : best_dist_s;
            grant_o     = take_s ? GW'(i) : grant_o;
            valid_o     = valid_o | take_s;
        end
    end

endmodule

// File: rtl/response_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ response sources.
// Build option RESPONSE_CHECKSUM_EN appends a code^data checksum byte to every frame.
module response_scheduler
    import response_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 32'd4,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int unsigned GW = (NUM_REQ > 32'd2) ? $clog2(NUM_REQ) : 32'd1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_code,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 tx_start,
    output logic [7:0]           tx_byte,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [GW-1:0]        grant_id,
    output logic                 timeout_error
);
    localparam int unsigned        CW = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 32'd1;
    localparam logic [CW-1:0]      WDOG_LIMIT     = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]      WDOG_ONE       = CW'(1);
    localparam logic [NUM_REQ-1:0] ACK_ONE        = NUM_REQ'(1);
    localparam logic [GW-1:0]      LAST_GRANT_RST = GW'(NUM_REQ - 32'd1);
    localparam bit                 WDOG_EN        = (TIMEOUT_CYCLES != 32'd0);

    state_t             state_q;
    logic [GW-1:0]      last_grant_q;
    logic [GW-1:0]      grant_id_q;
    logic [GW-1:0]      arb_grant_s;
    logic               arb_valid_s;
    logic [7:0]         code_q;
    logic [7:0]         data_q;
    logic [7:0]         tx_byte_q;
    logic [NUM_REQ-1:0] req_ack_q;
    logic               tx_start_q;
    logic               busy_q;
    logic               timeout_error_q;
    logic [CW-1:0]      wdog_q;
    logic [CW-1:0]      wdog_d;
    logic               wdog_expire_s;

    round_robin_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_arbiter (
        .req_valid_i  (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant_s),
        .valid_o      (arb_valid_s)
    );

    // Saturating wait count; expiry fires on the cycle the count reaches the limit, so the
    // registered timeout_error lands exactly TIMEOUT_CYCLES cycles after tx_start.
    always_comb begin
        wdog_d        = (wdog_q == {CW{1'b1}}) ? wdog_q : (wdog_q + WDOG_ONE);
        wdog_expire_s = WDOG_EN && (wdog_d == WDOG_LIMIT);
    end

    // Frame sequencer: grant and latch, then one SEND/WAIT pair per byte; tx_done beats expiry.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            last_grant_q    <= LAST_GRANT_RST;
            grant_id_q      <= '0;
            code_q          <= 8'h00;
            data_q          <= 8'h00;
            tx_byte_q       <= 8'h00;
            req_ack_q       <= '0;
            tx_start_q      <= 1'b0;
            busy_q          <= 1'b0;
            timeout_error_q <= 1'b0;
            wdog_q          <= '0;
        end else begin
            req_ack_q       <= '0;
            tx_start_q      <= 1'b0;
            timeout_error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid_s) begin
                        last_grant_q <= arb_grant_s;
                        grant_id_q   <= arb_grant_s;
                        code_q       <= req_code[{arb_grant_s, 3'b000} +: 8];
                        data_q       <= req_data[{arb_grant_s, 3'b000} +: 8];
                        req_ack_q    <= ACK_ONE << arb_grant_s;
                        busy_q       <= 1'b1;
                        state_q      <= ST_SEND_CODE;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_SEND_CODE: begin
                    tx_start_q <= 1'b1;
                    tx_byte_q  <= code_q;
                    wdog_q     <= '0;
                    state_q    <= ST_WAIT_CODE;
                end
                ST_WAIT_CODE: begin
                    if (tx_done) begin
                        state_q <= ST_SEND_DATA;
                    end else if (wdog_expire_s) begin
                        timeout_error_q <= 1'b1;
                        busy_q          <= 1'b0;
                        state_q         <= ST_IDLE;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                ST_SEND_DATA: begin
                    tx_start_q <= 1'b1;
                    tx_byte_q  <= data_q;
                    wdog_q     <= '0;
                    state_q    <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (tx_done) begin
`ifdef RESPONSE_CHECKSUM_EN
                        state_q <= ST_SEND_SUM;
`else
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
`endif
                    end else if (wdog_expire_s) begin
                        timeout_error_q <= 1'b1;
                        busy_q          <= 1'b0;
                        state_q         <= ST_IDLE;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
`ifdef RESPONSE_CHECKSUM_EN
                ST_SEND_SUM: begin
                    tx_start_q <= 1'b1;
                    tx_byte_q  <= frame_checksum(code_q, data_q);
                    wdog_q     <= '0;
                    state_q    <= ST_WAIT_SUM;
                end
                ST_WAIT_SUM: begin
                    if (tx_done) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (wdog_expire_s) begin
                        timeout_error_q <= 1'b1;
                        busy_q          <= 1'b0;
                        state_q         <= ST_IDLE;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
`endif
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ack       = req_ack_q;
    assign tx_start      = tx_start_q;
    assign tx_byte       = tx_byte_q;
    assign busy          = busy_q;
    assign grant_id      = grant_id_q;
    assign timeout_error = timeout_error_q;

endmodule

// File: doc/response_scheduler.md
# response_scheduler

Shares the single UART transmitter between several response sources (sensor channels, error reporter) that each produce a two-byte reply: response code, then data byte. Round-robin arbitration picks one pending requester, latches its bytes, and sequences them into the UART_TX handshake byte by byte. A watchdog aborts a frame if the transmitter stops acknowledging. Sits between the per-channel response producers and `UART_TX`, replacing direct producer-to-transmitter wiring.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 100000: max cycles to wait for `tx_done` per byte; 0 disables the watchdog.
- `clock` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: requester i has a frame pending; held until `req_ack[i]`.
- `req_code` in 8*NUM_REQ: response code of requester i, bits [8i+7:8i].
- `req_data` in 8*NUM_REQ: data byte of requester i, same packing.
- `req_ack` out NUM_REQ: one-cycle pulse, frame of requester i latched.
- `tx_start` out 1: one-cycle pulse, `tx_byte` valid for UART_TX.
- `tx_byte` out 8: byte to transmit, stable from `tx_start` until next `tx_start`.
- `tx_done` in 1: one-cycle pulse from UART_TX, byte fully shifted out.
- `busy` out 1: high from grant until frame end or abort.
- `grant_id` out max(1,$clog2(NUM_REQ)): index of current/last granted requester.
- `timeout_error` out 1: one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, SEND_CODE, WAIT_CODE, SEND_DATA, WAIT_DATA (+ SEND_SUM, WAIT_SUM with checksum).
- IDLE: if any `req_valid`, choose first set bit searching upward from `last_grant+1` with wrap; latch code/data, set `grant_id`, pulse `req_ack`, `busy`=1, go SEND_CODE. No valid: stay.
- SEND_CODE: pulse `tx_start`, `tx_byte`=code, clear watchdog, go WAIT_CODE.
- WAIT_CODE: on `tx_done` go SEND_DATA; else count; on count == TIMEOUT_CYCLES pulse `timeout_error`, go IDLE.
- SEND_DATA / WAIT_DATA: same with data byte; on `tx_done` go IDLE (or SEND_SUM), `busy`=0.
- `last_grant` updates only at grant; aborted frames are not retried.
- `tx_done` outside WAIT_* states ignored.
- `tx_done` and watchdog expiry in same cycle: `tx_done` wins, no error.
- `req_valid` dropped before ack: request lost, not served. Inputs of non-granted requesters ignored while busy.
- Watchdog counter width $clog2(TIMEOUT_CYCLES+1), saturates; never wraps.

## Timing
- Reset: `req_ack`=0, `tx_start`=0, `tx_byte`=8'h00, `busy`=0, `grant_id`=0, `timeout_error`=0, state IDLE, `last_grant`=NUM_REQ-1 (requester 0 first).
- All outputs registered.
- `req_valid` seen at cycle N in IDLE: `req_ack` and `busy` high at N+1, `tx_start` with code at N+2.
- `tx_done` at cycle M in WAIT_CODE: `tx_start` with data at M+2.
- `tx_done` at cycle M in last WAIT state: `busy` low at M+1; next grant evaluated at M+1, earliest `req_ack` M+2.
- Reset mid-frame: immediate return to reset values; frame discarded, no further `tx_start`.

## Configuration
- `RESPONSE_CHECKSUM_EN` defined: third byte sent after data, value code XOR data, via SEND_SUM/WAIT_SUM with same watchdog rules; `busy` drops after its `tx_done`.
- Not defined: two-byte frames only; SEND_SUM/WAIT_SUM absent.

## Structure
- Shared package: state encodings, `RESPONSE_FRAME_BYTES` (2, or 3 with checksum), default `TIMEOUT_CYCLES`.
- Sub-module `round_robin_arbiter`: combinational next-grant from `req_valid` and `last_grant`, returns index and any-valid flag.

## Test plan
- Single request: req 2 code 8'h01 data 8'h2A, tx_done 10 cycles after each start -> ack[2] at N+1, tx_byte 8'h01 then 8'h2A, busy low after second tx_done.
- All four valid at once from reset -> grant order 0,1,2,3, each ack once, eight bytes in order.
- Fairness: req 1 held continuously, req 3 pending -> grants alternate 1,3,1,3.
- Watchdog: TIMEOUT_CYCLES=16, no tx_done after code -> timeout_error 16 cycles after tx_start, data byte never sent, IDLE next.
- tx_done in expiry cycle -> no timeout_error, data byte sent; reset asserted in WAIT_DATA -> all outputs zero next cycle, no tx_start.
- With `RESPONSE_CHECKSUM_EN`: code 8'h03 data 8'h5C -> third byte 8'h5F.
